// File: rtl/rs15_9_pkg.sv
// Shared RS(15,9) over GF(16) definitions: field constants, generator
// coefficients and encoder FSM encodings.
package rs15_9_pkg;

   localparam int SYM_W = 4;
   localparam int N     = 15;
   localparam int K     = 9;
   localparam int NPAR  = N - K;

   typedef logic [SYM_W-1:0] sym_t;

   // x^4 = x + 1, the x^4 term itself is implicit
   localparam sym_t PRIM_POLY = 4'b0011;

   // alpha^i, index i = 0..14
   localparam logic [N-1:0][SYM_W-1:0] ALPHA_TBL = {
      4'h9, 4'hD, 4'hF, 4'hE, 4'h7, 4'hA, 4'h5, 4'hB,
      4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1
   };

   // g5..g0 of the monic generator; g6 = 1 is implicit in the LFSR feedback
   localparam logic [NPAR-1:0][SYM_W-1:0] GEN_COEF = {
      4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hC
   };

   localparam logic [3:0] LAST_SYM = 4'(K - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } enc_state_e;

endpackage

// File: rtl/rs15_9_encoder_gf16_mul.sv
// Combinational GF(16) multiplier, shift-and-add reduced by x^4+x+1.
// With one operand tied to a constant, synthesis folds it to a few XORs.
module gf16_mul
   import rs15_9_pkg::*;
(
   input  logic [SYM_W-1:0] a_i,
   input  logic [SYM_W-1:0] b_i,
   output logic [SYM_W-1:0] p_o
);

   sym_t acc;
   sym_t shifted;

   // NOTE: blocking is intended here; acc and shifted evolve in loop order.
   always_comb begin
      acc     = '0;
      shifted = a_i;
      for (int i = 0; i < SYM_W; i++) begin
         if (b_i[i]) acc = acc ^ shifted;
         shifted = {shifted[SYM_W-2:0], 1'b0} ^ (shifted[SYM_W-1] ? PRIM_POLY : '0);
      end
      p_o = acc;
   end

endmodule

// File: rtl/rs15_9_encoder.sv
// Systematic RS(15,9) encoder: serial LFSR division by g(x), one message
// symbol per clock, highest degree first; 60-bit codeword after 10 busy cycles.
module rs15_9_encoder
   import rs15_9_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [35:0]  messageIn,
   input  logic         encodeMessage,
   output logic         encoderBusy,
   output logic [59:0]  codewordOut,
   output logic         codewordValid
);

   enc_state_e                    state_q, state_d;
   logic [K-1:0][SYM_W-1:0]       msg_q, msg_d;
   logic [NPAR-1:0][SYM_W-1:0]    par_q, par_d;
   logic [3:0]                    cnt_q, cnt_d;
   logic [59:0]                   cw_q, cw_d;
   logic                          valid_q, valid_d;

   sym_t                          fb;
   logic [NPAR-1:0][SYM_W-1:0]    prod;

   assign fb = msg_q[cnt_q] ^ par_q[NPAR-1];

   for (genvar gi = 0; gi < NPAR; gi++) begin : g_coef_mul
      gf16_mul u_mul (
         .a_i (fb),
         .b_i (GEN_COEF[gi]),
         .p_o (prod[gi])
      );
   end

   // NOTE: every *_d gets its default first, so no branch can infer a latch.
   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      par_d   = par_q;
      cnt_d   = cnt_q;
      cw_d    = cw_q;
      valid_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (encodeMessage) begin
               msg_d   = messageIn;
               par_d   = '0;
               cnt_d   = LAST_SYM;
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            par_d[0] = prod[0];
            for (int i = 1; i < NPAR; i++) begin
               par_d[i] = par_q[i-1] ^ prod[i];
            end
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_DONE: begin
            cw_d    = {msg_q, par_q};
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: synchronous reset; non-blocking so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         msg_q   <= '0;
         par_q   <= '0;
         cnt_q   <= '0;
         cw_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         par_q   <= par_d;
         cnt_q   <= cnt_d;
         cw_q    <= cw_d;
         valid_q <= valid_d;
      end
   end

   assign encoderBusy   = (state_q != ST_IDLE);
   assign codewordOut   = cw_q;
   assign codewordValid = valid_q;

endmodule

// File: tb/tb_rs15_9_encoder.sv
// Scoreboard bench for rs15_9_encoder: directed messages with hand-derived
// codewords, plus a syndrome evaluation of every codeword the DUT presents.
module tb_rs15_9_encoder;
   import rs15_9_pkg::*;

   logic         clk;
   logic         rst_n;
   logic [35:0]  messageIn;
   logic         encodeMessage;
   logic         encoderBusy;
   logic [59:0]  codewordOut;
   logic         codewordValid;

   int n_checks   = 0;
   int n_fail     = 0;
   int n_expected = 0;
   int n_valid    = 0;

   logic [59:0] exp_q[$];
   logic [59:0] mon_exp;

   typedef struct {
      logic [35:0] msg;
      logic [59:0] cw;
   } vec_t;

   localparam int NVEC = 12;
   vec_t vecs [NVEC] = '{
      '{36'h000000000, 60'h000000000000000},
      '{36'h000000001, 60'h000000001793CAC},
      '{36'h000000002, 60'h000000002E16B7B},
      '{36'h000000003, 60'h0000000039857D7},
      '{36'h000000010, 60'h000000010F958F2},
      '{36'h000000011, 60'h00000001180645E},
      '{36'h000000100, 60'h0000001002BA7E8},
      '{36'h100000000, 60'h100000000A35D18},
      '{36'h200000000, 60'h20000000076A923},
      '{36'h100000001, 60'h100000001DA61B4},
      '{36'h111111111, 60'h111111111111111},
      '{36'hFFFFFFFFF, 60'hFFFFFFFFFFFFFFF}
   };

   int held_idx [3] = '{10, 9, 8};

   rs15_9_encoder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .messageIn     (messageIn),
      .encodeMessage (encodeMessage),
      .encoderBusy   (encoderBusy),
      .codewordOut   (codewordOut),
      .codewordValid (codewordValid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp_v);
      end
   endtask

   // S_j = c(alpha^j), evaluated through the antilog table
   function automatic logic [3:0] syndrome(input logic [59:0] cw, input int j);
      logic [3:0] s;
      logic [3:0] sym;
      int         lg;
      s = '0;
      for (int i = 0; i < N; i++) begin
         sym = cw[4*i +: 4];
         if (sym != 4'h0) begin
            lg = 0;
            for (int e = 0; e < N; e++) if (ALPHA_TBL[e] == sym) lg = e;
            s = s ^ ALPHA_TBL[(lg + i * j) % N];
         end
      end
      return s;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (codewordValid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 64'(codewordValid), 64'(0));
            end else begin
               mon_exp = exp_q.pop_front();
               check("codeword", 64'(codewordOut), 64'(mon_exp));
               for (int j = 1; j <= NPAR; j++) begin
                  check($sformatf("syndrome_S%0d", j), 64'(syndrome(codewordOut, j)), 64'(0));
               end
            end
         end
      end
   end

   task automatic run_encode(input logic [35:0] msg, input logic [59:0] cw);
      int busy_cycles;
      messageIn     = msg;
      encodeMessage = 1'b1;
      exp_q.push_back(cw);
      n_expected++;
      @(negedge clk);
      encodeMessage = 1'b0;
      messageIn     = {4'($urandom), $urandom};
      busy_cycles   = 0;
      while (encoderBusy === 1'b1 && busy_cycles < 20) begin
         busy_cycles++;
         @(negedge clk);
      end
      check("busy_len", 64'(busy_cycles), 64'(10));
      @(negedge clk);
      check("valid_one_cycle", 64'(codewordValid), 64'(0));
      check("cw_hold", 64'(codewordOut), 64'(cw));
   endtask

   initial begin
      int w;
      rst_n         = 1'b0;
      encodeMessage = 1'b0;
      messageIn     = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(encoderBusy), 64'(0));
      check("reset_valid", 64'(codewordValid), 64'(0));
      check("reset_cw", 64'(codewordOut), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < NVEC; v++) begin
         run_encode(vecs[v].msg, vecs[v].cw);
      end

      // start held high, junk on messageIn between accepted starts
      encodeMessage = 1'b1;
      for (int i = 0; i < 33; i++) begin
         if (i % 11 == 0) begin
            messageIn = vecs[held_idx[i/11]].msg;
            exp_q.push_back(vecs[held_idx[i/11]].cw);
            n_expected++;
         end else begin
            messageIn = {4'($urandom), $urandom};
         end
         @(negedge clk);
      end
      encodeMessage = 1'b0;
      w = 0;
      while (encoderBusy === 1'b1 && w < 20) begin
         w++;
         @(negedge clk);
      end
      check("held_idle", 64'(encoderBusy), 64'(0));
      @(negedge clk);

      // reset in the middle of an encode
      messageIn     = vecs[4].msg;
      encodeMessage = 1'b1;
      @(negedge clk);
      encodeMessage = 1'b0;
      messageIn     = {4'($urandom), $urandom};
      repeat (4) @(negedge clk);
      check("busy_before_abort", 64'(encoderBusy), 64'(1));
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(encoderBusy), 64'(0));
      check("abort_valid", 64'(codewordValid), 64'(0));
      check("abort_cw", 64'(codewordOut), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      run_encode(vecs[6].msg, vecs[6].cw);

      repeat (15) @(negedge clk);
      check("pending_expect", 64'(exp_q.size()), 64'(0));
      check("valid_count", 64'(n_valid), 64'(n_expected));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule
